uart_cmd_responder: RTL and testbench

Byte-level command responder on the host side of `top_uart`. It consumes received bytes (`rx_valid`/`rx_data`), parses fixed-length read/write command frames, and issues single-beat transactions on a simple memory request bus that will front the QSPI controller. It returns one response byte per frame through the UART transmit handshake (`tx_valid`/`tx_data`).

---
 rtl/uart_cmd_pkg.sv | 20 ++
 rtl/uart_cmd_timeout.sv | 33 +++
 rtl/uart_cmd_responder.sv | 196 +++++++++++++++++++
 tb/tb_uart_cmd_responder.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared constants and state encoding for the UART command responder.
package uart_cmd_pkg;

  // Command opcodes (first byte of a frame)
  localparam logic [7:0] OP_WR   = 8'h57;
  localparam logic [7:0] OP_RD   = 8'h52;

  // Response bytes returned to the host
  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_ADDR,
    ST_GET_DATA,
    ST_MEM,
    ST_SEND
  } state_t;

endpackage

// File: rtl/uart_cmd_timeout.sv
// Loadable down-counter that flags expiry after LIMIT enabled cycles.
// Load starts a new window; the flag asserts on the LIMIT-th enabled cycle.
module uart_cmd_timeout #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_load,
  input  logic i_en,
  output logic o_expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] r_cnt;

  // Count down while enabled; a load restarts the window and wins over clear
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CW'(LIMIT - 1);
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_expired = i_en && (r_cnt == '0);

endmodule

// File: rtl/uart_cmd_responder.sv
// Parses fixed-length read/write frames from the UART receiver, performs one
// memory transaction per frame and returns a single response byte.
module uart_cmd_responder
  import uart_cmd_pkg::*;
#(
  parameter int DATA_BIT    = 8,
  parameter int ADDR_W      = 8,
  parameter int GAP_TIMEOUT = 100000,
  parameter int MEM_TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rx_valid,
  input  logic [DATA_BIT-1:0] rx_data,
  output logic                rx_ready,
  output logic                tx_valid,
  output logic [DATA_BIT-1:0] tx_data,
  input  logic                tx_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_BIT-1:0] mem_wdata,
  input  logic                mem_ack,
  input  logic [DATA_BIT-1:0] mem_rdata,
  output logic                busy,
  output logic [7:0]          err_cnt
);

  state_t              r_state;
  state_t              w_state_nx;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_BIT-1:0] r_mem_wdata;
  logic [DATA_BIT-1:0] r_tx_data;
  logic [7:0]          r_err_cnt;

  logic                w_acc;
  logic                w_is_op;
  logic                w_gap_en;
  logic                w_gap_exp;
  logic                w_mem_exp;
  logic                w_to_clr;
  logic                w_cap_op;
  logic                w_cap_addr;
  logic                w_cap_data;
  logic                w_go_mem;
  logic                w_mem_done;
  logic                w_ld_tx;
  logic                w_ld_nak;
  logic [DATA_BIT-1:0] w_tx_nx;

  assign rx_ready = (r_state == ST_IDLE) || (r_state == ST_GET_ADDR) ||
                    (r_state == ST_GET_DATA);
  assign w_acc    = rx_valid && rx_ready;
  assign w_is_op  = (rx_data == DATA_BIT'(OP_WR)) || (rx_data == DATA_BIT'(OP_RD));
  assign w_gap_en = (r_state == ST_GET_ADDR) || (r_state == ST_GET_DATA);
  assign w_to_clr = (r_state == ST_IDLE) || (r_state == ST_SEND);

  // Inter-byte gap watchdog, restarted by every accepted byte
  uart_cmd_timeout #(.LIMIT(GAP_TIMEOUT)) u_gap_to (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_to_clr),
    .i_load    (w_acc),
    .i_en      (w_gap_en),
    .o_expired (w_gap_exp)
  );

  // Memory acknowledge watchdog, restarted on entry to MEM
  uart_cmd_timeout #(.LIMIT(MEM_TIMEOUT)) u_mem_to (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_to_clr),
    .i_load    (w_go_mem),
    .i_en      (r_state == ST_MEM),
    .o_expired (w_mem_exp)
  );

  // State register
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) r_state <= ST_IDLE;
    else       r_state <= w_state_nx;
  end

  // Next-state decode and per-cycle load strobes for the output registers
  always_comb begin
    w_state_nx = r_state;
    w_cap_op   = 1'b0;
    w_cap_addr = 1'b0;
    w_cap_data = 1'b0;
    w_go_mem   = 1'b0;
    w_mem_done = 1'b0;
    w_ld_tx    = 1'b0;
    w_ld_nak   = 1'b0;
    w_tx_nx    = '0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_acc) begin
          if (w_is_op) begin
            w_cap_op   = 1'b1;
            w_state_nx = ST_GET_ADDR;
          end else begin
            w_ld_tx    = 1'b1;
            w_ld_nak   = 1'b1;
            w_tx_nx    = DATA_BIT'(RSP_NAK);
            w_state_nx = ST_SEND;
          end
        end
      end
      ST_GET_ADDR: begin
        if (w_acc) begin
          w_cap_addr = 1'b1;
          if (r_mem_we) begin
            w_state_nx = ST_GET_DATA;
          end else begin
            w_go_mem   = 1'b1;
            w_state_nx = ST_MEM;
          end
        end else if (w_gap_exp) begin
          w_ld_tx    = 1'b1;
          w_ld_nak   = 1'b1;
          w_tx_nx    = DATA_BIT'(RSP_NAK);
          w_state_nx = ST_SEND;
        end
      end
      ST_GET_DATA: begin
        if (w_acc) begin
          w_cap_data = 1'b1;
          w_go_mem   = 1'b1;
          w_state_nx = ST_MEM;
        end else if (w_gap_exp) begin
          w_ld_tx    = 1'b1;
          w_ld_nak   = 1'b1;
          w_tx_nx    = DATA_BIT'(RSP_NAK);
          w_state_nx = ST_SEND;
        end
      end
      ST_MEM: begin
        if (mem_ack) begin
          w_mem_done = 1'b1;
          w_ld_tx    = 1'b1;
          w_tx_nx    = r_mem_we ? DATA_BIT'(RSP_ACK) : mem_rdata;
          w_state_nx = ST_SEND;
        end else if (w_mem_exp) begin
          w_mem_done = 1'b1;
          w_ld_tx    = 1'b1;
          w_ld_nak   = 1'b1;
          w_tx_nx    = DATA_BIT'(RSP_NAK);
          w_state_nx = ST_SEND;
        end
      end
      ST_SEND: begin
        if (tx_ready) w_state_nx = ST_IDLE;
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  // Memory bus registers: fields captured while parsing, request held until done
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      if (w_cap_op)   r_mem_we    <= (rx_data == DATA_BIT'(OP_WR));
      if (w_cap_addr) r_mem_addr  <= rx_data[ADDR_W-1:0];
      if (w_cap_data) r_mem_wdata <= rx_data;
      if (w_go_mem)        r_mem_req <= 1'b1;
      else if (w_mem_done) r_mem_req <= 1'b0;
    end
  end

  // Response byte and saturating NAK counter
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_tx_data <= '0;
      r_err_cnt <= 8'd0;
    end else begin
      if (w_ld_tx) r_tx_data <= w_tx_nx;
      if (w_ld_nak && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign tx_valid  = (r_state == ST_SEND);
  assign tx_data   = r_tx_data;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = (r_state != ST_IDLE);
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Testbench for uart_cmd_responder: frame vectors, memory model, tx scoreboard.
module tb_uart_cmd_responder;

  localparam int GAP_T   = 40;
  localparam int MEM_T   = 30;
  localparam int ACK_LAT = 3;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       mem_req;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_ack;
  logic [7:0] mem_rdata;
  logic       busy;
  logic [7:0] err_cnt;

  uart_cmd_responder #(
    .DATA_BIT(8), .ADDR_W(8), .GAP_TIMEOUT(GAP_T), .MEM_TIMEOUT(MEM_T)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt = 0;
  int total    = 0;
  int exp_err  = 0;
  int acc_cyc  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // ---------------- memory model ----------------
  logic [7:0] mem [256];
  int   req_cnt = 0, req_total = 0, last_len = 0, req_start_cyc = 0, ack_cyc = 0;
  bit   ack_en = 1'b1, inject_ack = 1'b0, stable_err = 1'b0;
  logic       last_we;
  logic [7:0] last_addr, last_wdata;

  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (inject_ack) begin
        mem_ack    = 1'b1;
        mem_rdata  = 8'hEE;
        inject_ack = 1'b0;
      end else if (mem_req) begin
        if (req_cnt == 0) begin
          last_we = mem_we; last_addr = mem_addr; last_wdata = mem_wdata;
          req_start_cyc = cyc;
          req_total++;
        end else if (mem_we !== last_we || mem_addr !== last_addr || mem_wdata !== last_wdata) begin
          stable_err = 1'b1;
        end
        req_cnt++;
        if (ack_en && req_cnt == ACK_LAT) begin
          mem_ack = 1'b1;
          ack_cyc = cyc;
          if (mem_we) mem[mem_addr] = mem_wdata;
          else        mem_rdata = mem[mem_addr];
        end
      end else begin
        if (req_cnt > 0) last_len = req_cnt;
        req_cnt = 0;
      end
    end
  end

  // ---------------- tx scoreboard ----------------
  logic [7:0] exp_q [$];
  bit prev_txv = 1'b0;
  int rise_cyc = 0;

  always @(negedge clk) begin
    if (tx_valid && !prev_txv) rise_cyc = cyc;
    prev_txv = tx_valid;
    if (tx_valid && tx_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_tx: got byte %0h, expected no byte", tx_data);
      end else begin
        chk("rsp", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    while (!rx_ready && t < 200) begin @(negedge clk); t++; end
    if (!rx_ready) begin
      total++;
      $display("FAIL rx_accept: byte %0h not accepted, expected acceptance", b);
    end
    acc_cyc = cyc;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    do begin @(negedge clk); t++; end
    while ((exp_q.size() != 0 || busy) && t < 1000);
    if (exp_q.size() != 0 || busy) begin
      total++;
      $display("FAIL wait_idle: pending %0d busy %0b, expected 0 and 0", exp_q.size(), busy);
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic bump_err();
    if (exp_err < 255) exp_err++;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] b0, b1, b2;
    int         n;
    logic [7:0] rsp;
    bit         nak;
    bit         is_mem;
    bit         we;
    logic [7:0] addr, wdata;
  } vec_t;

  localparam int NV = 8;
  vec_t vt [NV];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  r0;
    int  g_acc;
    int  t;
    bit  ok;

    vt[0] = '{8'h57, 8'h10, 8'hA5, 3, ACK,   1'b0, 1'b1, 1'b1, 8'h10, 8'hA5};
    vt[1] = '{8'h52, 8'h10, 8'h00, 2, 8'hA5, 1'b0, 1'b1, 1'b0, 8'h10, 8'h00};
    vt[2] = '{8'h57, 8'h00, 8'h3C, 3, ACK,   1'b0, 1'b1, 1'b1, 8'h00, 8'h3C};
    vt[3] = '{8'h57, 8'hFF, 8'h81, 3, ACK,   1'b0, 1'b1, 1'b1, 8'hFF, 8'h81};
    vt[4] = '{8'h52, 8'hFF, 8'h00, 2, 8'h81, 1'b0, 1'b1, 1'b0, 8'hFF, 8'h00};
    vt[5] = '{8'h33, 8'h00, 8'h00, 1, NAK,   1'b1, 1'b0, 1'b0, 8'h00, 8'h00};
    vt[6] = '{8'h52, 8'h00, 8'h00, 2, 8'h3C, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00};
    vt[7] = '{8'h00, 8'h00, 8'h00, 1, NAK,   1'b1, 1'b0, 1'b0, 8'h00, 8'h00};

    rst_n = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rx_ready", rx_ready, 1);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_cnt", err_cnt, 0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      r0 = req_total;
      stable_err = 1'b0;
      exp_q.push_back(vt[i].rsp);
      if (vt[i].nak) bump_err();
      send_byte(vt[i].b0);
      if (vt[i].n > 1) send_byte(vt[i].b1);
      if (vt[i].n > 2) send_byte(vt[i].b2);
      wait_idle();
      chk("vec_err_cnt", err_cnt, exp_err);
      if (vt[i].is_mem) begin
        chk("vec_mem_we", last_we, vt[i].we);
        chk("vec_mem_addr", last_addr, vt[i].addr);
        if (vt[i].we) chk("vec_mem_wdata", last_wdata, vt[i].wdata);
        chk("vec_req_latency", req_start_cyc, acc_cyc + 1);
        chk("vec_ack_to_tx", rise_cyc, ack_cyc + 1);
        chk("vec_req_len", last_len, ACK_LAT);
        chk("vec_mem_stable", stable_err, 0);
      end else begin
        chk("vec_no_req", req_total, r0);
        chk("vec_nak_latency", rise_cyc, acc_cyc + 1);
      end
    end

    // tx back-pressure: response must hold for 50 stalled cycles
    tx_ready = 1'b0;
    exp_q.push_back(NAK);
    bump_err();
    send_byte(8'h33);
    t = 0;
    @(negedge clk);
    while (!tx_valid && t < 20) begin @(negedge clk); t++; end
    ok = tx_valid;
    for (int k = 0; k < 50; k++) begin
      if (!(tx_valid === 1'b1 && tx_data === NAK)) ok = 1'b0;
      @(negedge clk);
    end
    chk("stall_stable", ok, 1);
    chk("stall_err_cnt", err_cnt, exp_err);
    @(posedge clk); #1;
    tx_ready = 1'b1;
    wait_idle();

    // inter-byte gap timeout in GET_DATA, then a normal read of the same address
    r0 = req_total;
    exp_q.push_back(NAK);
    bump_err();
    send_byte(8'h57);
    send_byte(8'h20);
    g_acc = acc_cyc;
    wait_idle();
    chk("gap_no_req", req_total, r0);
    chk("gap_latency", rise_cyc, g_acc + GAP_T + 1);
    chk("gap_err_cnt", err_cnt, exp_err);
    exp_q.push_back(8'h00);
    send_byte(8'h52);
    send_byte(8'h20);
    wait_idle();
    chk("gap_next_addr", last_addr, 8'h20);
    chk("gap_next_we", last_we, 0);

    // memory timeout, then a late ack that must be ignored
    ack_en = 1'b0;
    exp_q.push_back(NAK);
    bump_err();
    send_byte(8'h52);
    send_byte(8'h10);
    wait_idle();
    ack_en = 1'b1;
    chk("memto_req_len", last_len, MEM_T);
    chk("memto_err_cnt", err_cnt, exp_err);
    inject_ack = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("late_ack_busy", busy, 0);
    chk("late_ack_tx_valid", tx_valid, 0);
    chk("late_ack_err_cnt", err_cnt, exp_err);
    exp_q.push_back(8'hA5);
    send_byte(8'h52);
    send_byte(8'h10);
    wait_idle();

    // NAK counter saturation
    for (int k = 0; k < 260; k++) begin
      exp_q.push_back(NAK);
      bump_err();
      send_byte(8'h33);
      wait_idle();
    end
    chk("err_cnt_sat", err_cnt, 255);

    // asynchronous reset while a read is waiting in MEM
    ack_en = 1'b0;
    send_byte(8'h52);
    send_byte(8'h00);
    t = 0;
    @(negedge clk);
    while (!mem_req && t < 20) begin @(negedge clk); t++; end
    chk("pre_rst_mem_req", mem_req, 1);
    @(posedge clk); #2;
    rst_n = 1'b1;
    #1;
    chk("arst_mem_req", mem_req, 0);
    chk("arst_busy", busy, 0);
    chk("arst_tx_valid", tx_valid, 0);
    chk("arst_err_cnt", err_cnt, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n  = 1'b0;
    ack_en = 1'b1;
    exp_err = 0;
    @(posedge clk); #1;
    exp_q.push_back(8'h3C);
    send_byte(8'h52);
    send_byte(8'h00);
    wait_idle();
    chk("post_rst_addr", last_addr, 8'h00);
    chk("post_rst_err_cnt", err_cnt, 0);

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
